// File: rtl/ppu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ppu_pkg
//  Description : Shared types, constants and helpers for the PPU framebuffer
//                writer. When PPU_FB_DOUBLE_BUFFER_EN is defined, the address
//                gains a bank bit.
//  Revision    : 1.0 - initial release
// ============================================================================
package ppu_pkg;

    // PPU mode as reported by the STAT mode bits
    typedef enum logic [1:0] {
        H_BLANK = 2'd0,
        V_BLANK = 2'd1,
        SCAN    = 2'd2,
        DRAW    = 2'd3
    } PPU_MODE_t;

    // Frame tracking state of the framebuffer writer
    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        VBLANK    = 2'd1,
        ACTIVE    = 2'd2,
        DRAIN     = 2'd3
    } fb_state_t;

    localparam int FB_BYTES_PER_LINE = 40;
    localparam int FB_LINE_PX        = 160;
    localparam int FB_LINES          = 144;

    // 5760 bytes fit in 13 bits; the bank bit sits above that
    localparam int FB_BASE_W = 13;
`ifdef PPU_FB_DOUBLE_BUFFER_EN
    localparam int FB_ADDR_W = FB_BASE_W + 1;
`else
    localparam int FB_ADDR_W = FB_BASE_W;
`endif
    localparam int FB_ENTRY_W = FB_ADDR_W + 8;

    // BGP lookup: colour index n selects palette bits [2n+1:2n]
    function automatic logic [1:0] fb_shade(input logic [7:0] pal, input logic [1:0] idx);
        return pal[{idx, 1'b0} +: 2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/ppu_fb_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : ppu_fb_fifo
//  Description : Small synchronous FIFO holding {addr,data} framebuffer writes.
//                Push while full is accepted when a pop happens in the same
//                cycle. Synchronous clear empties it.
//  Revision    : 1.0 - initial release
// ============================================================================
module ppu_fb_fifo
    import ppu_pkg::*;
#(
    parameter int WIDTH = FB_ENTRY_W,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_PTR_W = $clog2(DEPTH);

    // Pointers carry one wrap bit so full and empty can be told apart
    logic [c_PTR_W:0]  r_wr_ptr;
    logic [c_PTR_W:0]  r_rd_ptr;
    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic              w_do_push;
    logic              w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                       (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_head    = r_mem[r_rd_ptr[c_PTR_W-1:0]];

    // Pointer update; clear has priority over any push/pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Entry storage; zeroed on reset so the idle head reads as 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_do_push && !i_clr) begin
            r_mem[r_wr_ptr[c_PTR_W-1:0]] <= i_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ppu_fb_writer.sv
`default_nettype none
// ============================================================================
//  Module      : ppu_fb_writer
//  Description : PPU pixel sink. Maps colour indices through BGP, packs four
//                2-bit shades per byte and writes a 160x144 framebuffer through
//                a small write FIFO. Tracks frames from PPU mode changes.
//                Optional: PPU_FB_DOUBLE_BUFFER_EN adds a bank bit on fb_addr
//                and a display_bank output.
//  Revision    : 1.0 - initial release
// ============================================================================
module ppu_fb_writer
    import ppu_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int LINE_PX    = FB_LINE_PX,
    parameter int LINES      = FB_LINES
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 lcd_en,
    input  logic [1:0]           ppu_mode,
    input  logic [1:0]           px_in,
    input  logic                 px_valid,
    input  logic [7:0]           bgp,
    output logic                 fb_we,
    output logic [FB_ADDR_W-1:0] fb_addr,
    output logic [7:0]           fb_wdata,
    input  logic                 fb_ready,
    output logic                 frame_done,
    output logic                 overflow
`ifdef PPU_FB_DOUBLE_BUFFER_EN
    ,
    output logic                 display_bank
`endif
);

    localparam int                   c_X_W   = $clog2(LINE_PX + 1);
    localparam int                   c_Y_W   = $clog2(LINES + 1);
    localparam logic [c_X_W-1:0]     c_X_MAX = c_X_W'(LINE_PX);
    localparam logic [c_Y_W-1:0]     c_Y_MAX = c_Y_W'(LINES);
    localparam logic [FB_BASE_W-1:0] c_BPL   = FB_BASE_W'(LINE_PX / 4);

    fb_state_t              r_state;
    fb_state_t              w_state_nxt;
    PPU_MODE_t              w_mode;
    PPU_MODE_t              r_mode_q;

    logic [c_X_W-1:0]       r_x;
    logic [c_Y_W-1:0]       r_y;
    logic [FB_BASE_W-1:0]   r_line_base;
    logic [1:0]             r_pack_cnt;
    logic [5:0]             r_pack_sr;
    logic                   r_overflow;
    logic                   r_frame_done;

    logic                   w_frame_start;
    logic                   w_frame_end;
    logic                   w_px_take;
    logic                   w_eol;
    logic                   w_flush;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_drop;
    logic [1:0]             w_shade;
    logic [7:0]             w_full_byte;
    logic [7:0]             w_flush_byte;
    logic [FB_BASE_W-1:0]   w_byte_addr;
    logic [FB_ADDR_W-1:0]   w_push_addr;
    logic [FB_ENTRY_W-1:0]  w_push_data;
    logic [FB_ENTRY_W-1:0]  w_head;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;

    assign w_mode = PPU_MODE_t'(ppu_mode);

    // Pixel path: accepted only while drawing a visible pixel of a visible line
    assign w_px_take   = (r_state == ACTIVE) && lcd_en && (w_mode == DRAW) && px_valid &&
                         (r_x < c_X_MAX) && (r_y < c_Y_MAX);
    assign w_eol       = (r_state == ACTIVE) && lcd_en && (r_mode_q == DRAW) && (w_mode == H_BLANK);
    assign w_flush     = w_eol && (r_pack_cnt != 2'd0) && (r_y < c_Y_MAX);
    assign w_shade     = fb_shade(bgp, px_in);
    assign w_full_byte = {r_pack_sr, w_shade};

    // Incremental addressing: line base plus the byte index within the line
    assign w_byte_addr = r_line_base + FB_BASE_W'(r_x[c_X_W-1:2]);

    // Partial byte at end of line: received shades left-aligned, zeros below
    always_comb begin
        w_flush_byte = 8'h00;
        case (r_pack_cnt)
            2'd1:    w_flush_byte = {r_pack_sr[1:0], 6'b0};
            2'd2:    w_flush_byte = {r_pack_sr[3:0], 4'b0};
            2'd3:    w_flush_byte = {r_pack_sr[5:0], 2'b0};
            default: w_flush_byte = 8'h00;
        endcase
    end

    assign w_push      = (w_px_take && (r_pack_cnt == 2'd3)) || w_flush;
    assign w_push_data = {w_push_addr, (w_px_take ? w_full_byte : w_flush_byte)};
    assign w_pop       = !w_fifo_empty && fb_ready;
    assign w_drop      = w_push && w_fifo_full && !w_pop;

    ppu_fb_fifo #(
        .WIDTH (FB_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (!lcd_en),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign fb_we                = !w_fifo_empty;
    assign {fb_addr, fb_wdata}  = w_head;
    assign frame_done           = r_frame_done;
    assign overflow             = r_overflow;

    // Frame state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= WAIT_SYNC;
        else        r_state <= w_state_nxt;
    end

    // Frame tracking: next state, frame start and frame end events
    always_comb begin
        w_state_nxt   = r_state;
        w_frame_start = 1'b0;
        w_frame_end   = 1'b0;
        if (!lcd_en) begin
            w_state_nxt = WAIT_SYNC;
        end else begin
            case (r_state)
                WAIT_SYNC: begin
                    if (w_mode == V_BLANK) w_state_nxt = VBLANK;
                end
                VBLANK: begin
                    if (w_mode == SCAN) begin
                        w_state_nxt   = ACTIVE;
                        w_frame_start = 1'b1;
                    end
                end
                ACTIVE: begin
                    if ((w_mode == V_BLANK) && (r_mode_q != V_BLANK)) w_state_nxt = DRAIN;
                end
                DRAIN: begin
                    if (w_fifo_empty) begin
                        w_state_nxt = VBLANK;
                        w_frame_end = 1'b1;
                    end
                end
                default: w_state_nxt = WAIT_SYNC;
            endcase
        end
    end

    // Mode history, pixel position, line base and shade packing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode_q    <= H_BLANK;
            r_x         <= '0;
            r_y         <= '0;
            r_line_base <= '0;
            r_pack_cnt  <= 2'd0;
            r_pack_sr   <= 6'd0;
        end else begin
            r_mode_q <= w_mode;
            if (w_frame_start) begin
                r_x         <= '0;
                r_y         <= '0;
                r_line_base <= '0;
                r_pack_cnt  <= 2'd0;
                r_pack_sr   <= 6'd0;
            end else if (w_px_take) begin
                r_x        <= r_x + 1'b1;
                r_pack_cnt <= r_pack_cnt + 2'd1;
                r_pack_sr  <= {r_pack_sr[3:0], w_shade};
            end else if (w_eol) begin
                r_x        <= '0;
                r_pack_cnt <= 2'd0;
                r_pack_sr  <= 6'd0;
                // y and base stop past the last visible line
                if (r_y < c_Y_MAX) begin
                    r_y         <= r_y + 1'b1;
                    r_line_base <= r_line_base + c_BPL;
                end
            end
        end
    end

    // Sticky overflow and registered frame-complete pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_frame_end;
            if (w_frame_start)  r_overflow <= 1'b0;
            else if (w_drop)    r_overflow <= 1'b1;
        end
    end

`ifdef PPU_FB_DOUBLE_BUFFER_EN
    logic r_bank;

    // Write bank flips together with the frame_done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           r_bank <= 1'b0;
        else if (w_frame_end) r_bank <= ~r_bank;
    end

    assign w_push_addr  = {r_bank, w_byte_addr};
    assign display_bank = ~r_bank;
`else
    assign w_push_addr  = w_byte_addr;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ppu_fb_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ppu_fb_writer
//  Description : Self-checking bench for ppu_fb_writer with a queue-based
//                reference model and directed plus randomized frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ppu_fb_writer;
    import ppu_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = FB_ADDR_W;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          lcd_en   = 1'b0;
    logic [1:0]    ppu_mode = 2'd0;
    logic [1:0]    px_in    = 2'd0;
    logic          px_valid = 1'b0;
    logic [7:0]    bgp      = 8'h00;
    logic          fb_ready = 1'b1;
    logic          fb_we;
    logic [AW-1:0] fb_addr;
    logic [7:0]    fb_wdata;
    logic          frame_done;
    logic          overflow;
`ifdef PPU_FB_DOUBLE_BUFFER_EN
    logic          display_bank;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ppu_fb_writer #(
        .FIFO_DEPTH (DEPTH),
        .LINE_PX    (160),
        .LINES      (144)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .lcd_en       (lcd_en),
        .ppu_mode     (ppu_mode),
        .px_in        (px_in),
        .px_valid     (px_valid),
        .bgp          (bgp),
        .fb_we        (fb_we),
        .fb_addr      (fb_addr),
        .fb_wdata     (fb_wdata),
        .fb_ready     (fb_ready),
        .frame_done   (frame_done),
        .overflow     (overflow)
`ifdef PPU_FB_DOUBLE_BUFFER_EN
        ,
        .display_bank (display_bank)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Pending writes as (addr << 8) | data, in issue order
    logic [31:0] mq[$];
    int          m_phase = 0;   // 0 waiting for vblank, 1 in vblank, 2 frame open, 3 draining
    int          m_line  = 0;
    int          m_npx   = 0;
    int          m_acc   = 0;
    bit          m_ovf   = 0;
    bit          m_fd    = 0;
    bit          m_bank  = 0;
    int          m_prev  = 0;

    function automatic logic [31:0] mk(input int a13, input int b);
        int a;
        a = a13;
`ifdef PPU_FB_DOUBLE_BUFFER_EN
        a = a13 + (m_bank ? 8192 : 0);
`endif
        return (32'(a) << 8) | 32'(b & 255);
    endfunction

    task automatic model_step();
        bit          pop;
        bit          push;
        logic [31:0] ent;
        int          sh;
        int          mode;
        mode = int'(ppu_mode);
        pop  = (mq.size() > 0) && fb_ready;
        push = 0;
        ent  = 0;
        m_fd = 0;
        if (!lcd_en) begin
            mq.delete();
            m_phase = 0;
        end else begin
            case (m_phase)
                0: if (mode == 1) m_phase = 1;
                1: if (mode == 2) begin
                       m_phase = 2; m_line = 0; m_npx = 0; m_acc = 0; m_ovf = 0;
                   end
                2: begin
                    if (mode == 3 && px_valid && m_npx < 160 && m_line < 144) begin
                        sh    = (int'(bgp) >> (2 * int'(px_in))) & 3;
                        m_acc = m_acc * 4 + sh;
                        m_npx++;
                        if (m_npx % 4 == 0) begin
                            push  = 1;
                            ent   = mk(m_line * 40 + m_npx / 4 - 1, m_acc);
                            m_acc = 0;
                        end
                    end else if (m_prev == 3 && mode == 0) begin
                        if (m_npx % 4 != 0 && m_line < 144) begin
                            push = 1;
                            ent  = mk(m_line * 40 + m_npx / 4, m_acc << (2 * (4 - m_npx % 4)));
                        end
                        if (m_line < 144) m_line++;
                        m_npx = 0;
                        m_acc = 0;
                    end else if (mode == 1 && m_prev != 1) begin
                        m_phase = 3;
                    end
                end
                default: if (mq.size() == 0) begin
                    m_fd = 1; m_phase = 1; m_bank = !m_bank;
                end
            endcase
            if (pop) void'(mq.pop_front());
            if (push) begin
                if (mq.size() < DEPTH) mq.push_back(ent);
                else                   m_ovf = 1;
            end
        end
        m_prev = mode;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                mq.delete();
                m_phase = 0; m_line = 0; m_npx = 0; m_acc = 0;
                m_ovf = 0; m_fd = 0; m_bank = 0; m_prev = 0;
            end else begin
                model_step();
            end
        end
    end

    // ---------------- compare process and write log ----------------
    logic [31:0] wlog[$];
    int          fd_cnt = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("fb_we", 32'(fb_we), 32'(mq.size() > 0));
                if (mq.size() > 0) begin
                    check("fb_addr", 32'(fb_addr), mq[0] >> 8);
                    check("fb_wdata", 32'(fb_wdata), mq[0] & 32'hFF);
                end
                check("frame_done", 32'(frame_done), 32'(m_fd));
                check("overflow", 32'(overflow), 32'(m_ovf));
`ifdef PPU_FB_DOUBLE_BUFFER_EN
                check("display_bank", 32'(display_bank), 32'(!m_bank));
`endif
                if (fb_we && fb_ready) wlog.push_back(32'({fb_addr, fb_wdata}));
                if (frame_done) fd_cnt++;
            end
        end
    end

    function automatic logic [31:0] logw(input int i);
        if (i >= 0 && i < wlog.size()) return wlog[i];
        return 32'hFFFF_FFFF;
    endfunction

    // ---------------- stimulus ----------------
    int ready_mode = 1;   // 0 never ready, 1 always ready, 2 random
    int pmode      = 0;   // 0 index = px%4, 1 constant, 2 random
    int pconst     = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        if (ready_mode == 2) fb_ready = ($urandom_range(0, 3) != 0);
        else                 fb_ready = (ready_mode == 1);
    endtask

    function automatic logic [1:0] next_px(input int i);
        if (pmode == 0) return 2'(i % 4);
        if (pmode == 1) return 2'(pconst);
        return 2'($urandom_range(0, 3));
    endfunction

    task automatic hold(input logic [1:0] m, input int n);
        ppu_mode = m;
        px_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic draw(input int npx, input bit vrand);
        int i;
        i = 0;
        ppu_mode = 2'd3;
        while (i < npx) begin
            px_valid = vrand ? ($urandom_range(0, 3) != 0) : 1'b1;
            px_in    = px_valid ? next_px(i) : 2'($urandom_range(0, 3));
            if (px_valid) i++;
            tick();
        end
        px_valid = 1'b0;
    endtask

    task automatic frame(input int nlines, input int npx, input bit vrand);
        for (int l = 0; l < nlines; l++) begin
            hold(2'd2, 2);
            draw(npx, vrand);
            hold(2'd0, 3);
        end
        hold(2'd1, 24);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        check("rst_fb_we", 32'(fb_we), 0);
        check("rst_fb_addr", 32'(fb_addr), 0);
        check("rst_fb_wdata", 32'(fb_wdata), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_overflow", 32'(overflow), 0);
        rst_n  = 1'b1;
        lcd_en = 1'b1;
        tick();

        // Start in the middle of a frame: nothing may be written
        bgp = 8'hE4; pmode = 0;
        wlog.delete();
        draw(40, 0); hold(2'd0, 3); hold(2'd2, 2); draw(40, 0); hold(2'd0, 3);
        check("midframe_writes", 32'(wlog.size()), 0);
        hold(2'd1, 5);

        // Full frame, two extra lines and four extra pixels per line are dropped
        wlog.delete(); fd_cnt = 0;
        frame(146, 164, 0);
        check("full_count", 32'(wlog.size()), 5760);
        check("full_last_addr", (logw(wlog.size() - 1) >> 8) & 32'h1FFF, 5759);
        n = 0;
        for (int i = 0; i < wlog.size(); i++) if ((wlog[i] & 32'hFF) != 32'h1B) n++;
        check("full_bytes_1b", 32'(n), 0);
        check("full_frame_done", 32'(fd_cnt), 1);
        check("full_overflow", 32'(overflow), 0);
`ifdef PPU_FB_DOUBLE_BUFFER_EN
        check("bank_f0", (logw(0) >> 21) & 32'h1, 0);
        check("disp_after_f0", 32'(display_bank), 0);
`endif

        // Palette: bgp 0x1B with index 0 -> shade 3 everywhere
        bgp = 8'h1B; pmode = 1; pconst = 0;
        wlog.delete();
        frame(1, 160, 0);
        check("bgp1b_count", 32'(wlog.size()), 40);
        check("bgp1b_byte", logw(0) & 32'hFF, 32'hFF);
        check("bgp1b_last", logw(39) & 32'h1FFFFF, (32'd39 << 8) | 32'hFF);
`ifdef PPU_FB_DOUBLE_BUFFER_EN
        check("bank_f1", (logw(0) >> 21) & 32'h1, 1);
`endif
        bgp = 8'h00; pmode = 2;
        wlog.delete();
        frame(1, 160, 0);
        check("bgp00_byte", logw(7) & 32'hFF, 32'h00);
`ifdef PPU_FB_DOUBLE_BUFFER_EN
        check("bank_f2", (logw(0) >> 21) & 32'h1, 0);
`endif

        // Short lines: 150 px -> 37 bytes plus flush of pixels 148,149
        bgp = 8'hE4; pmode = 0;
        wlog.delete();
        frame(2, 150, 0);
        check("short_count", 32'(wlog.size()), 76);
        check("short_flush", logw(37) & 32'h1FFFFF, (32'd37 << 8) | 32'h10);
        check("short_next_line", (logw(38) >> 8) & 32'h1FFF, 40);

        // Backpressure: 5 bytes into a 4-deep FIFO with the RAM stalled
        wlog.delete();
        hold(2'd2, 2);
        ready_mode = 0; fb_ready = 1'b0;
        draw(20, 0);
        check("ovf_set", 32'(overflow), 1);
        ready_mode = 1; fb_ready = 1'b1;
        hold(2'd0, 3);
        hold(2'd1, 24);
        check("ovf_kept", 32'(wlog.size()), 4);
        check("ovf_sticky", 32'(overflow), 1);
        hold(2'd2, 2);
        check("ovf_cleared", 32'(overflow), 0);

        // LCD switched off mid-line with writes pending
        ready_mode = 0; fb_ready = 1'b0;
        draw(24, 0);
        check("lcd_pre_we", 32'(fb_we), 1);
        lcd_en = 1'b0;
        tick();
        check("lcd_off_we", 32'(fb_we), 0);
        ready_mode = 1; fb_ready = 1'b1;
        hold(2'd3, 6);
        lcd_en = 1'b1;
        wlog.delete();
        draw(30, 0); hold(2'd0, 2); hold(2'd2, 2); draw(30, 0); hold(2'd0, 2);
        check("lcd_resync_writes", 32'(wlog.size()), 0);
        hold(2'd1, 5);
        wlog.delete();
        frame(1, 16, 0);
        check("lcd_restart_addr", logw(0) & 32'h1FFFFF, 32'h1B);

        // Randomized frames with random pixels, valid gaps and RAM stalls
        ready_mode = 2;
        for (int f = 0; f < 8; f++) begin
            bgp   = 8'($urandom);
            pmode = 2;
            frame($urandom_range(1, 5), $urandom_range(0, 170), 1);
        end
        ready_mode = 1;
        hold(2'd1, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ppu_fb_writer.md
Name: ppu_fb_writer

Overview:
- Pixel sink directly downstream of the PPU pixel FIFO. It consumes one 2-bit colour index per valid cycle and maps it through BGP to a shade.
- It packs 4 shades per byte and writes the bytes to a 160x144 framebuffer RAM (40 bytes per line, 5760 bytes) through a small write FIFO with backpressure.
- It tracks the frame from PPU mode transitions and tells the display side when a frame is complete.

Parameters:
- FIFO_DEPTH, 4: entries in the write FIFO ({addr,data}); power of 2, minimum 2.
- LINE_PX, 160: visible pixels per line.
- LINES, 144: visible lines per frame.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- lcd_en  in  1  LCDC[7]; low = LCD off.
- ppu_mode  in  2  PPU mode: 0 H_BLANK, 1 V_BLANK, 2 SCAN, 3 DRAW.
- px_in  in  2  PPU colour index.
- px_valid  in  1  px_in is valid this cycle.
- bgp  in  8  BG palette (FF47).
- fb_we  out  1  framebuffer write strobe.
- fb_addr  out  13  byte address (14 bits with the optional feature).
- fb_wdata  out  8  packed shades; pixel 0 in [7:6], pixel 3 in [1:0].
- fb_ready  in  1  RAM accepts a write this cycle.
- frame_done  out  1  one-cycle pulse when a frame is fully written.
- overflow  out  1  sticky flag: a byte was dropped because the FIFO was full.

Behaviour:
- Reset values: fb_we=0, fb_addr=0, fb_wdata=0, frame_done=0, overflow=0. Internal: state=WAIT_SYNC, x=0, y=0, line base=0, pack count=0, FIFO empty.
- Mode edges are detected against a registered copy of ppu_mode.
- Palette: shade = bgp[2*px_in+1 : 2*px_in], sampled in the cycle px_valid is high.
- Packing: shades shift in MSB-first. When the 4th shade arrives, {line base + x/4, byte} is pushed in the same cycle. x counts 0..159.
- Address generation is incremental: the byte address is line base + pack index, and line base advances by 40 per line. No multiplier.
- Write port:
  - fb_we = FIFO not empty; fb_addr and fb_wdata come from the FIFO head.
  - The entry pops on fb_we && fb_ready.
  - A push and a pop in the same cycle are both legal, including when the FIFO is full (pop frees the slot).
- Overflow: if the FIFO is full with no pop and a push is due, the byte is dropped and overflow is set. overflow clears only on reset or on entry to ACTIVE.
- State machine:
  - WAIT_SYNC: ignores pixels. Goes to VBLANK when ppu_mode==1. Prevents writing a partial first frame.
  - VBLANK: ignores pixels. When ppu_mode==2, goes to ACTIVE with x=0, y=0, line base=0, overflow=0.
  - ACTIVE: accepts pixels while ppu_mode==3.
    - On a 3->0 edge (end of line): any partial byte (1-3 shades) is padded with shade 00 in the low slots and pushed. Then y++, line base += 40, x=0, pack count=0.
    - On entry to mode 1: goes to DRAIN.
  - DRAIN: when the FIFO is empty, pulses frame_done for 1 cycle and goes to VBLANK.
- Boundary rules:
  - Pixels with x>=160 are dropped.
  - Lines with y>=144 are dropped entirely.
  - px_valid outside DRAW mode or outside ACTIVE is ignored.
  - A line ending while the FIFO is full causes the flush byte to be dropped and sets overflow.
- lcd_en low, in any state: next cycle the state is WAIT_SYNC, the FIFO is cleared synchronously, fb_we=0, and no frame_done is pulsed.
- Latency: the 4th pixel at cycle N gives fb_we at N+1 if the FIFO was empty and fb_ready is high.

Optional Feature:
- PPU_FB_DOUBLE_BUFFER_EN defined:
  - fb_addr is 14 bits, with bit 13 = write bank.
  - Extra output display_bank (1 bit) = ~write bank; reset write bank=0.
  - The write bank toggles in the same cycle as frame_done.
  - The display side reads only display_bank, so it never sees a partly written frame.
- Undefined: fb_addr is 13 bits, single buffer, no display_bank port.

Decomposition:
- Package ppu_pkg:
  - PPU_MODE_t enum {H_BLANK=0, V_BLANK=1, SCAN=2, DRAW=3}.
  - FB state enum {WAIT_SYNC, VBLANK, ACTIVE, DRAIN}.
  - Constants FB_BYTES_PER_LINE=40, FB_LINE_PX=160, FB_LINES=144.
- Sub-module ppu_fb_fifo: synchronous FIFO, width 21 (22 with the optional feature), depth FIFO_DEPTH. It has push, pop, sync clear, full and empty; simultaneous push/pop is legal when full.

Test Plan:
- Full frame, fb_ready=1, bgp=0xE4, px_in pattern 0,1,2,3 repeated on 160 px x 144 lines -> 5760 writes, every byte 0x1B, last addr 5759, one frame_done after the V_BLANK edge, overflow=0.
- bgp=0x1B, one line of px_in=0 -> each byte 0xFF; bgp=0x00 -> 0x00.
- Line ends after 150 px: 37 full bytes plus flush byte with pixels 148,149 padded -> byte 0x?? layout [7:4] data, [3:0]=0. The next line starts at addr 40.
- fb_ready=0 for 20 cycles during DRAW, FIFO_DEPTH=4 -> overflow=1 and only 4 bytes retained. overflow clears at the next SCAN after V_BLANK.
- lcd_en dropped mid-line -> fb_we=0 next cycle. No writes until V_BLANK then SCAN; the next frame starts at addr 0.
- Frame starting mid-frame after reset (first mode seen =3) -> no writes until the first V_BLANK then SCAN. With PPU_FB_DOUBLE_BUFFER_EN, fb_addr[13] alternates 0,1,0 across 3 frames and display_bank is always the opposite.
